boot_loader: RTL and testbench

UART bootloader and instruction-memory controller placed between the UART receiver, a single-port instruction RAM and the CPU fetch port. After reset it holds the CPU in reset and receives a program image over UART. Each received word is written to the RAM. When loading completes, it releases the CPU and hands the RAM read port to instruction fetch. The CPU fetch path keeps the existing behaviour: byte address in, word index = addr[30:2], out-of-range fetch returns 0.

---
 rtl/boot_loader_pkg.sv | 23 ++
 rtl/boot_timeout.sv | 36 +++
 rtl/boot_loader.sv | 153 +++++++++++++++
 tb/tb_boot_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// +---------------------------------------------------------------------------+
// | boot_loader_pkg : loader states and UART image-format constants           |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

package boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    WORD   = 3'd2,
    WRITE  = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } boot_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/boot_timeout.sv
// +---------------------------------------------------------------------------+
// | boot_timeout : idle-cycle counter with clear/enable, flags TIMEOUT reached |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module boot_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT));

  // Saturates at TIMEOUT so the flag stays up until the loader reacts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// +---------------------------------------------------------------------------+
// | boot_loader : UART image loader into instruction RAM, then CPU fetch path |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int MEM_WORDS = 128,
  parameter int ADDR_W    = 7,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              load_req,
  input  logic [30:0]       cpu_addr,
  output logic [31:0]       cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam logic [28:0] FETCH_LIMIT = 29'(MEM_WORDS);
  localparam logic [15:0] MAX_COUNT   = 16'(MEM_WORDS);
  localparam logic [1:0]  LAST_BYTE   = 2'(WORD_BYTES - 1);

  boot_state_t state;
  logic [15:0] word_count;
  logic [1:0]  byte_idx;
  logic [23:0] shift_reg;
  logic        timeout_hit;
  logic        timing;
  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic [15:0] next_loaded;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, cpu_addr[1:0]};

  assign timing      = (state == HDR_LO) || (state == WORD) || (state == WRITE);
  assign hdr_count   = {word_count[15:8], rx_data};
  assign hdr_bad     = (hdr_count == 16'd0) || (hdr_count > MAX_COUNT);
  assign next_loaded = words_loaded + 16'd1;

  boot_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear   (rx_valid || load_req),
    .enable  (timing),
    .expired (timeout_hit)
  );

  assign mem_we   = (state == WRITE);
  assign mem_addr = (state == RUN) ? cpu_addr[ADDR_W+1:2] : words_loaded[ADDR_W-1:0];
  assign cpu_data = ((state == RUN) && (cpu_addr[30:2] < FETCH_LIMIT)) ? mem_rdata : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HDR_HI;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b1;
      err          <= 1'b0;
      mem_wdata    <= 32'd0;
      words_loaded <= 16'd0;
      word_count   <= 16'd0;
      byte_idx     <= 2'd0;
      shift_reg    <= 24'd0;
    end else if (load_req) begin
      state        <= HDR_HI;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b1;
      err          <= 1'b0;
      words_loaded <= 16'd0;
      byte_idx     <= 2'd0;
    end else begin
      case (state)
        HDR_HI: begin
          if (rx_valid) begin
            word_count[15:8] <= rx_data;
            state            <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (rx_valid) begin
            word_count <= hdr_count;
            if (hdr_bad) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WORD;
            end
          end else if (timeout_hit) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        WORD: begin
          if (rx_valid) begin
            shift_reg <= {shift_reg[15:0], rx_data};
            if (byte_idx == LAST_BYTE) begin
              mem_wdata <= {shift_reg, rx_data};
              byte_idx  <= 2'd0;
              state     <= WRITE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (timeout_hit) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        WRITE: begin
          words_loaded <= next_loaded;
          if (next_loaded == word_count) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= WORD;
            // A byte landing here is the first byte of the next word.
            if (rx_valid) begin
              shift_reg <= {shift_reg[15:0], rx_data};
              byte_idx  <= 2'd1;
            end
          end
        end
        RUN: begin
        end
        ERR: begin
        end
        default: begin
          state <= ERR;
          err   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// +---------------------------------------------------------------------------+
// | tb_boot_loader : randomized image loads checked by a write scoreboard     |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_boot_loader;

  localparam int MEM_WORDS = 128;
  localparam int ADDR_W    = 7;
  localparam int TIMEOUT   = 50;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              load_req = 1'b0;
  logic [30:0]       cpu_addr = 31'd0;
  logic [31:0]       cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              err;
  logic [15:0]       words_loaded;

  int checks = 0;
  int passes = 0;

  logic [31:0] ram [MEM_WORDS];
  logic [31:0] img [MEM_WORDS];
  logic [38:0] exp_writes [$];

  always #5 clk = ~clk;

  boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .load_req     (load_req),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .cpu_rst_n    (cpu_rst_n),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every RAM write must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_writes.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 39'h0);
      else check("ram_write", {mem_addr, mem_wdata}, exp_writes.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Builds a random n-word image, queues its expected writes and streams it.
  task automatic send_image(input int n, input int maxgap);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      img[k] = $urandom;
      exp_writes.push_back({7'(k), img[k]});
    end
    send_byte(8'(n >> 8), $urandom_range(maxgap, 0));
    send_byte(8'(n), $urandom_range(maxgap, 0));
    for (int k = 0; k < n; k++) begin
      w = img[k];
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], $urandom_range(maxgap, 0));
    end
  endtask

  task automatic wait_run(input int n);
    for (int i = 0; i < 8 && cpu_rst_n !== 1'b1; i++) tick();
    check("run_entry_cpu_rst_n", 39'(cpu_rst_n), 39'd1);
    check("run_busy", 39'(busy), 39'd0);
    check("run_err", 39'(err), 39'd0);
    check("run_words_loaded", 39'(words_loaded), 39'(n));
    check("pending_writes", 39'(exp_writes.size()), 39'd0);
  endtask

  task automatic fetch_checks(input int n);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(n - 1, 0);
      cpu_addr = {29'(k), 2'($urandom)};
      #1 check("fetch_in_range", 39'(cpu_data), 39'(img[k]));
    end
    cpu_addr = 31'(4 * MEM_WORDS) + 31'($urandom_range(3, 0));
    #1 check("fetch_at_limit", 39'(cpu_data), 39'd0);
    cpu_addr = 31'h7FFF_FFFC;
    #1 check("fetch_far", 39'(cpu_data), 39'd0);
    cpu_addr = 31'd0;
  endtask

  task automatic bad_header(input logic [15:0] n);
    pulse_load();
    check("reload_err", 39'(err), 39'd0);
    check("reload_busy", 39'(busy), 39'd1);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 1);
    check("bad_hdr_err", 39'(err), 39'd1);
    check("bad_hdr_cpu_held", 39'(cpu_rst_n), 39'd0);
    check("bad_hdr_busy", 39'(busy), 39'd0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 2);
    check("err_sticky", 39'(err), 39'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'd0;
    repeat (2) tick();
    check("rst_cpu_rst_n", 39'(cpu_rst_n), 39'd0);
    check("rst_busy", 39'(busy), 39'd1);
    check("rst_err", 39'(err), 39'd0);
    check("rst_mem_we", 39'(mem_we), 39'd0);
    check("rst_words_loaded", 39'(words_loaded), 39'd0);
    reset_n = 1'b1;
    tick();

    // Directed image from the test plan.
    img[0] = 32'h3C08_4000;
    img[1] = 32'h2109_000C;
    exp_writes.push_back({7'd0, img[0]});
    exp_writes.push_back({7'd1, img[1]});
    foreach (img[i]) if (i < 2) ;
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h3C, 0); send_byte(8'h08, 0); send_byte(8'h40, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h0C, 0);
    check("loading_cpu_data", 39'(cpu_data), 39'd0);
    wait_run(2);
    cpu_addr = 31'h4;
    #1 check("fetch_word1", 39'(cpu_data), 39'h2109_000C);
    fetch_checks(2);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    check("run_ignores_rx", 39'(words_loaded), 39'd2);

    bad_header(16'h0000);
    bad_header(16'h0081);
    bad_header(16'($urandom_range(65535, 129)));

    // Silence after a partial word must time out without writing.
    pulse_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'h55, 0);
    repeat (TIMEOUT - 5) tick();
    check("timeout_not_yet", 39'(err), 39'd0);
    repeat (10) tick();
    check("timeout_err", 39'(err), 39'd1);
    check("timeout_cpu_held", 39'(cpu_rst_n), 39'd0);
    pulse_load();
    n = $urandom_range(6, 1);
    send_image(n, 2);
    wait_run(n);
    fetch_checks(n);

    // Randomized loads, including back-to-back bytes landing in the write cycle.
    for (int t = 0; t < 4; t++) begin
      pulse_load();
      n = $urandom_range(10, 1);
      send_image(n, (t == 0) ? 0 : 3);
      wait_run(n);
      fetch_checks(n);
    end

    // load_req colliding with rx_valid drops the byte and restarts.
    pulse_load();
    img[0] = $urandom;
    exp_writes.push_back({7'd0, img[0]});
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    for (int b = 3; b >= 0; b--) send_byte(img[0][8*b +: 8], 0);
    send_byte(8'h12, 0);
    load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    tick();
    load_req = 1'b0; rx_valid = 1'b0;
    check("abort_words_loaded", 39'(words_loaded), 39'd0);
    check("abort_busy", 39'(busy), 39'd1);
    check("abort_cpu_held", 39'(cpu_rst_n), 39'd0);
    n = $urandom_range(5, 1);
    send_image(n, 1);
    wait_run(n);
    fetch_checks(n);

    // Asynchronous reset in the middle of a word.
    pulse_load();
    img[0] = $urandom | 32'h1;
    exp_writes.push_back({7'd0, img[0]});
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    for (int b = 3; b >= 0; b--) send_byte(img[0][8*b +: 8], 0);
    send_byte(8'h77, 0); send_byte(8'h66, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cpu_rst_n", 39'(cpu_rst_n), 39'd0);
    check("arst_busy", 39'(busy), 39'd1);
    check("arst_err", 39'(err), 39'd0);
    check("arst_mem_wdata", 39'(mem_wdata), 39'd0);
    check("arst_words_loaded", 39'(words_loaded), 39'd0);
    check("arst_mem_we", 39'(mem_we), 39'd0);
    tick();
    reset_n = 1'b1;
    tick();
    n = $urandom_range(8, 2);
    send_image(n, 1);
    wait_run(n);
    fetch_checks(n);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
